// File: rtl/switch_port_pkg.sv
// Shared definitions for the debounced switch port: register map, CTRL bit
// positions and the debounce FSM state encoding.
package switch_port_pkg;

    localparam logic [31:0] SW_DATA_ADDR = 32'hF0000014;
    localparam logic [31:0] SW_CTRL_ADDR = 32'hF0000114;

    localparam int CTRL_READY   = 0;
    localparam int CTRL_OVERRUN = 2;
    localparam int CTRL_IE      = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } deb_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Synchronises and debounces a switch bank using one shared stability counter.
// Latency: commit pulses DEBOUNCE_CYCLES+2 edges after a clean input change.
// No backpressure: commit is a single-cycle pulse that the parent always takes.
module switch_debouncer
    import switch_port_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int CNT_W           = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] sw_reg,
    output logic             commit,
    output logic [WIDTH-1:0] cand
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_t       state;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] sync;
    logic [CNT_W-1:0] cnt;

    // Decoded from registered state so sw_reg updates on the same edge the FSM leaves COUNT.
    assign commit = (state == ST_COUNT) && (sync == cand) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= '0;
            sync  <= '0;
            cand  <= '0;
            cnt   <= '0;
            state <= ST_IDLE;
        end else begin
            s1   <= value;
            sync <= s1;
            case (state)
                ST_IDLE: begin
                    if (sync != sw_reg) begin
                        cand  <= sync;
                        cnt   <= '0;
                        state <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (sync != cand) begin
                        // Bouncing back to the committed value is a glitch, not a new candidate.
                        if (sync == sw_reg) begin
                            state <= ST_IDLE;
                        end else begin
                            cand <= sync;
                            cnt  <= '0;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debounced_switch_port.sv
// Memory-mapped debounced switch input port with DATA/CTRL registers and interrupt.
// Latency: a clean switch change reaches DATA DEBOUNCE_CYCLES+3 edges later.
// No backpressure: a new commit before DATA is read sets overrun and overwrites.
module debounced_switch_port
    import switch_port_pkg::*;
#(
    parameter int          WIDTH           = 10,
    parameter int          DEBOUNCE_CYCLES = 10000,
    parameter int          CNT_W           = 14,
    parameter logic [31:0] DATA_ADDR       = SW_DATA_ADDR,
    parameter logic [31:0] CTRL_ADDR       = SW_CTRL_ADDR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      abus,
    input  logic [31:0]      dbus,
    input  logic             wren,
    input  logic [WIDTH-1:0] value,
    output logic [31:0]      dbusout,
    output logic             intr
);

    logic [WIDTH-1:0] sw_reg;
    logic [WIDTH-1:0] cand;
    logic             commit;
    logic             ready;
    logic             overrun;
    logic             ie;
    logic             data_rd;
    logic             ctrl_rd;
    logic             ctrl_wr;

    switch_debouncer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debouncer (
        .clk    (clk),
        .reset  (reset),
        .value  (value),
        .sw_reg (sw_reg),
        .commit (commit),
        .cand   (cand)
    );

    assign data_rd = !wren && (abus == DATA_ADDR);
    assign ctrl_rd = !wren && (abus == CTRL_ADDR);
    assign ctrl_wr =  wren && (abus == CTRL_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_reg  <= '0;
            ready   <= 1'b0;
            overrun <= 1'b0;
            ie      <= 1'b0;
        end else begin
            if (commit) begin
                sw_reg <= cand;
                ready  <= 1'b1;
            end else if (data_rd) begin
                ready <= 1'b0;
            end

            // A read in the commit cycle consumed the old value, so no overrun then.
            if (commit && ready && !data_rd) begin
                overrun <= 1'b1;
            end else if (data_rd || (ctrl_wr && !dbus[CTRL_OVERRUN])) begin
                overrun <= 1'b0;
            end

            if (ctrl_wr) begin
                ie <= dbus[CTRL_IE];
            end
        end
    end

    always_comb begin
        dbusout = '0;
        if (data_rd) begin
            dbusout = 32'(sw_reg);
        end else if (ctrl_rd) begin
            dbusout[CTRL_READY]   = ready;
            dbusout[CTRL_OVERRUN] = overrun;
            dbusout[CTRL_IE]      = ie;
        end
    end

    assign intr = ie & ready;

endmodule

// File: tb/tb_debounced_switch_port.sv
// Directed bench for debounced_switch_port with DEBOUNCE_CYCLES=4, WIDTH=10:
// commits land 7 edges after a value change; each step checks hand-computed values.
module tb_debounced_switch_port;

    localparam logic [31:0] DA = 32'hF0000014;
    localparam logic [31:0] CA = 32'hF0000114;
    localparam logic [31:0] OTHER = 32'hF0000018;

    logic        clk;
    logic        reset;
    logic [31:0] abus;
    logic [31:0] dbus;
    logic        wren;
    logic [9:0]  value;
    logic [31:0] dbusout;
    logic        intr;

    int errors = 0;
    int checks = 0;

    debounced_switch_port #(
        .WIDTH           (10),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .DATA_ADDR       (DA),
        .CTRL_ADDR       (CA)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .abus    (abus),
        .dbus    (dbus),
        .wren    (wren),
        .value   (value),
        .dbusout (dbusout),
        .intr    (intr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a read address; combinational dbusout settles before sampling.
    task automatic sel(input logic [31:0] a);
        wren = 1'b0;
        dbus = '0;
        abus = a;
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wren = 1'b1;
        abus = a;
        dbus = d;
        tick();
        wren = 1'b0;
        dbus = '0;
        abus = '0;
    endtask

    task automatic commit_val(input logic [9:0] v);
        value = v;
        sel(CA);
        tick(7);
    endtask

    initial begin
        reset = 1'b1;
        abus  = '0;
        dbus  = '0;
        wren  = 1'b0;
        value = '0;
        tick(2);
        reset = 1'b0;

        // 1: reset state and first commit latency
        sel(DA);    chk("rst_data",  dbusout, 32'h0);
        sel(CA);    chk("rst_ctrl",  dbusout, 32'h0);
        sel(OTHER); chk("rst_other", dbusout, 32'h0);
        chk("rst_intr", {31'b0, intr}, 32'h0);
        value = 10'h155;
        sel(CA);
        tick(6);
        chk("lat_edge6_ctrl", dbusout, 32'h0);
        tick();
        chk("lat_edge7_ctrl", dbusout, 32'h1);
        chk("lat_intr_ie0", {31'b0, intr}, 32'h0);
        sel(DA);    chk("lat_data", dbusout, 32'h155);
        tick();
        sel(CA);    chk("rd_clears_ready", dbusout, 32'h0);
        wr(DA, 32'hFFFF_FFFF);
        sel(DA);    chk("data_write_ignored", dbusout, 32'h155);
        wr(OTHER, 32'h104);
        sel(CA);    chk("other_write_ignored", dbusout, 32'h0);

        // return switches to 0
        commit_val(10'h000);
        chk("to_zero_ctrl", dbusout, 32'h1);
        sel(DA);    chk("to_zero_data", dbusout, 32'h0);
        tick();

        // 2: glitch shorter than the debounce window
        value = 10'h3FF;
        sel(CA);
        tick(3);
        value = 10'h000;
        tick(10);
        chk("glitch_ctrl", dbusout, 32'h0);
        chk("glitch_intr", {31'b0, intr}, 32'h0);

        // 3: overrun on two unread commits
        commit_val(10'h001);
        chk("ovr_first_ctrl", dbusout, 32'h1);
        commit_val(10'h002);
        chk("ovr_ctrl", dbusout, 32'h5);
        sel(DA);    chk("ovr_data", dbusout, 32'h2);
        tick();
        sel(CA);    chk("ovr_cleared", dbusout, 32'h0);

        // 4: interrupt enable and clear by DATA read
        wr(CA, 32'h100);
        sel(CA);    chk("ie_set_ctrl", dbusout, 32'h100);
        chk("ie_set_intr", {31'b0, intr}, 32'h0);
        commit_val(10'h003);
        chk("irq_ctrl", dbusout, 32'h101);
        chk("irq_intr", {31'b0, intr}, 32'h1);
        sel(DA);    chk("irq_data", dbusout, 32'h3);
        chk("irq_intr_before_edge", {31'b0, intr}, 32'h1);
        tick();
        chk("irq_intr_dropped", {31'b0, intr}, 32'h0);
        wr(CA, 32'h000);
        sel(CA);    chk("ie_clear", dbusout, 32'h0);

        // 5: overrun write semantics and commit coincident with DATA read
        commit_val(10'h004);
        commit_val(10'h005);
        chk("w1_pre", dbusout, 32'h5);
        wr(CA, 32'h104);
        sel(CA);    chk("w1_no_effect", dbusout, 32'h105);
        chk("w1_intr", {31'b0, intr}, 32'h1);
        wr(CA, 32'h100);
        sel(CA);    chk("w0_clears", dbusout, 32'h101);
        value = 10'h006;
        tick(6);
        sel(DA);    chk("coinc_old_data", dbusout, 32'h5);
        tick();
        sel(CA);    chk("coinc_ctrl", dbusout, 32'h101);
        sel(DA);    chk("coinc_new_data", dbusout, 32'h6);
        tick();
        wr(CA, 32'h000);
        commit_val(10'h007);
        chk("cw_first", dbusout, 32'h1);
        value = 10'h00F;
        tick(6);
        wr(CA, 32'h000);
        sel(CA);    chk("commit_beats_write", dbusout, 32'h5);
        sel(DA);    chk("cw_data", dbusout, 32'hF);
        tick();
        sel(CA);    chk("cw_cleared", dbusout, 32'h0);

        // 6: reset in the middle of a count
        wr(CA, 32'h100);
        value = 10'h0F0;
        sel(CA);
        tick(5);
        reset = 1'b1;
        #1;
        sel(CA);    chk("midrst_ctrl", dbusout, 32'h0);
        sel(DA);    chk("midrst_data", dbusout, 32'h0);
        chk("midrst_intr", {31'b0, intr}, 32'h0);
        tick();
        reset = 1'b0;
        sel(CA);
        tick(6);
        chk("post_rst_edge6", dbusout, 32'h0);
        tick();
        chk("post_rst_edge7", dbusout, 32'h1);
        sel(DA);    chk("post_rst_data", dbusout, 32'h0F0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
